// File: rtl/operand_stack16b.sv
// LIFO operand stack with registered TOS/NOS and sticky overflow/underflow flags.
// Latency: 1 cycle from request to outputs; no backpressure, illegal requests are dropped and flagged.
module operand_stack16b #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    nos_idx;
    logic             is_empty;
    logic             is_full;

    always_comb begin
        tos_d       = tos_q;
        nos_d       = nos_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mem_we      = 1'b0;
        mem_waddr   = count_q[AW-1:0];
        is_empty    = (count_q == '0);
        is_full     = (count_q == CNT_W'(DEPTH));
        // Modulo index arithmetic stays correct at count == DEPTH since AW drops the MSB.
        top_idx     = count_q[AW-1:0] - AW'(1);
        nos_idx     = count_q[AW-1:0] - AW'(3);

        case ({push, pop})
            2'b10: begin
                if (!is_full) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    tos_d   = din;
                    nos_d   = tos_q;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    count_d = count_q - CNT_W'(1);
                    tos_d   = nos_q;
                    nos_d   = (count_q >= CNT_W'(3)) ? mem_q[nos_idx] : '0;
                end else begin
                    underflow_d = 1'b1;
                end
            end
            2'b11: begin
                if (!is_empty) begin
                    mem_we    = 1'b1;
                    mem_waddr = top_idx;
                    tos_d     = din;
                end else begin
                    underflow_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tos_q       <= '0;
            nos_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tos_q       <= tos_d;
            nos_q       <= nos_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_waddr] <= din;
        end
    end

    assign tos       = tos_q;
    assign nos       = nos_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_operand_stack16b.sv
// Directed bench for operand_stack16b: stimulus queues expected state, a monitor compares after each edge.
module tb_operand_stack16b;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic        push;
    logic        pop;
    logic [15:0] tos;
    logic [15:0] nos;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    typedef struct packed {
        logic [15:0] tos;
        logic [15:0] nos;
        logic [4:0]  cnt;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t  exp_q [$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    stim_done = 1'b0;

    operand_stack16b #(.WIDTH(16), .DEPTH(16), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .push      (push),
        .pop       (pop),
        .tos       (tos),
        .nos       (nos),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Drive one request at the falling edge and queue the state expected after the next rising edge.
    task automatic step(input string nm, input logic r, input logic pu, input logic po,
                        input logic [15:0] d, input logic [15:0] et, input logic [15:0] en,
                        input logic [4:0] ec, input logic ee, input logic ef,
                        input logic eo, input logic eu);
        exp_t e;
        @(negedge clk);
        reset = r;
        push  = pu;
        pop   = po;
        din   = d;
        e = '{tos: et, nos: en, cnt: ec, empty: ee, full: ef, ovf: eo, unf: eu};
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t  e;
        exp_t  a;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = '{tos: tos, nos: nos, cnt: count, empty: empty, full: full,
                       ovf: overflow, unf: underflow};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got tos=%0d nos=%0d cnt=%0d e=%b f=%b ovf=%b unf=%b, want tos=%0d nos=%0d cnt=%0d e=%b f=%b ovf=%b unf=%b",
                             nm, a.tos, a.nos, a.cnt, a.empty, a.full, a.ovf, a.unf,
                             e.tos, e.nos, e.cnt, e.empty, e.full, e.ovf, e.unf);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        din   = '0;

        for (int i = 0; i < 5; i++)
            step("reset_with_push", 1, 1, 0, 16'hAAAA, 0, 0, 0, 1, 0, 0, 0);

        step("push10", 0, 1, 0, 16'd10, 10,  0, 1, 0, 0, 0, 0);
        step("push20", 0, 1, 0, 16'd20, 20, 10, 2, 0, 0, 0, 0);
        step("push30", 0, 1, 0, 16'd30, 30, 20, 3, 0, 0, 0, 0);
        step("pop1",   0, 0, 1, 16'd0,  20, 10, 2, 0, 0, 0, 0);
        step("pop2",   0, 0, 1, 16'd0,  10,  0, 1, 0, 0, 0, 0);
        step("pop3",   0, 0, 1, 16'd0,   0,  0, 0, 1, 0, 0, 0);
        step("pop_empty_underflow", 0, 0, 1, 16'd0, 0, 0, 0, 1, 0, 0, 1);
        step("hold_sticky_unf",     0, 0, 0, 16'd5, 0, 0, 0, 1, 0, 0, 1);

        for (int k = 1; k <= 16; k++)
            step("fill", 0, 1, 0, 16'(k), 16'(k), 16'(k - 1), 5'(k), 0, (k == 16), 0, 1);

        step("push_full_overflow", 0, 1, 0, 16'd99, 16, 15, 16, 0, 1, 1, 1);
        step("replace_at_full",    0, 1, 1, 16'd77, 77, 15, 16, 0, 1, 1, 1);
        step("pop_deep_refill1",   0, 0, 1, 16'd0,  15, 14, 15, 0, 0, 1, 1);
        step("pop_deep_refill2",   0, 0, 1, 16'd0,  14, 13, 14, 0, 0, 1, 1);

        step("reset_clears_flags", 1, 0, 1, 16'd0, 0, 0, 0, 1, 0, 0, 0);
        step("push4",      0, 1, 0, 16'd4, 4, 0, 1, 0, 0, 0, 0);
        step("push5",      0, 1, 0, 16'd5, 5, 4, 2, 0, 0, 0, 0);
        step("replace9",   0, 1, 1, 16'd9, 9, 4, 2, 0, 0, 0, 0);
        step("pop_to4",    0, 0, 1, 16'd0, 4, 0, 1, 0, 0, 0, 0);
        step("pop_to0",    0, 0, 1, 16'd0, 0, 0, 0, 1, 0, 0, 0);
        step("replace_empty_unf", 0, 1, 1, 16'h1234, 0, 0, 0, 1, 0, 0, 1);

        step("pre_reset_push1", 0, 1, 0, 16'd1, 1, 0, 1, 0, 0, 0, 1);
        step("pre_reset_push2", 0, 1, 0, 16'd2, 2, 1, 2, 0, 0, 0, 1);
        step("pre_reset_push3", 0, 1, 0, 16'd3, 3, 2, 3, 0, 0, 0, 1);
        step("reset_with_pop",  1, 0, 1, 16'd0, 0, 0, 0, 1, 0, 0, 0);
        step("push42",          0, 1, 0, 16'd42, 42, 0, 1, 0, 0, 0, 0);
        step("hold42",          0, 0, 0, 16'd7,  42, 0, 1, 0, 0, 0, 0);

        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        repeat (3) @(posedge clk);
        stim_done = 1'b1;
    end

    initial begin : finisher
        fork
            wait (stim_done);
            begin
                #100000;
                $display("FAIL watchdog: stimulus did not complete, got timeout, want completion");
                n_fail++;
            end
        join_any
        disable fork;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
